adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
- Upstream write-side controller for the dual-port sample BRAM.
- Accepts a streaming ADC sample bus, waits for an armed trigger, decimates, and writes a programmable number of samples to sequential BRAM addresses starting at 0.
- Flags completion so the SPI readout side can drain the buffer through the BRAM read port.

Parameters:
- RAM_WIDTH, 8, sample and BRAM word width.
- RAM_ADDR_BITS, 16, BRAM address width; depth = 2**RAM_ADDR_BITS.
- DECIM_BITS, 8, width of the decimation ratio input.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- adc_data  input  RAM_WIDTH  ADC sample, valid when adc_valid=1.
- adc_valid  input  1  one-cycle sample strobe.
- arm  input  1  pulse; starts a capture sequence.
- abort  input  1  pulse; cancels any capture in progress.
- trigger  input  1  synchronous trigger level; the rising edge is used.
- capture_len  input  RAM_ADDR_BITS  samples to store minus 1 (0 = 1 sample, all-ones = full depth).
- decim  input  DECIM_BITS  store one of every decim+1 valid samples.
- write_enable  output  1  BRAM write strobe.
- write_address  output  RAM_ADDR_BITS  BRAM write address.
- write_data  output  RAM_WIDTH  BRAM write data.
- busy  output  1  high in ARMED or CAPTURE.
- capture_done  output  1  level; high in DONE.
- last_address  output  RAM_ADDR_BITS  address of the final sample written.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0.
  - The trigger edge register, sample counter and decimation counter are cleared.
- States: IDLE, ARMED, CAPTURE, DONE (2-bit enum).
- IDLE or DONE + arm -> ARMED:
  - capture_len and decim are latched.
  - The address counter is set to 0 and capture_done clears.
- ARMED + (trigger=1 and previous trigger=0) -> CAPTURE.
  - The decimation counter is set to 0.
  - No sample is taken in the edge cycle.
  - A trigger already high at arm time does not fire; a fresh rising edge is required.
- CAPTURE, on each cycle with adc_valid=1:
  - If decim_cnt==0, the sample is stored.
  - decim_cnt increments and wraps to 0 after reaching the latched decim.
  - decim=0 stores every valid sample.
- Store timing:
  - write_enable, write_address and write_data are registered and assert exactly 1 cycle after the accepting adc_valid cycle, for 1 cycle.
  - The address is the current counter value, which then increments.
- Store of the last sample (address == latched capture_len) -> DONE.
  - last_address is loaded with that address.
  - capture_done rises in the same cycle as the final write_enable.
- DONE: no further writes; capture_done holds until the next arm or reset.
- arm while ARMED or CAPTURE is ignored.
- abort in any state -> IDLE on the next edge:
  - Any write already registered for the abort cycle still completes; no further writes follow.
  - capture_done=0.
  - abort has priority over arm and over trigger in the same cycle.
- Full-depth capture (capture_len all-ones):
  - The address counter must not wrap before DONE.
  - Compare against capture_len, not the counter overflow.
- busy = state is ARMED or CAPTURE, registered.
- adc_valid in IDLE, ARMED or DONE is ignored.
- Asynchronous reset mid-capture: immediate return to IDLE and all outputs low. BRAM contents are left as written.

Decomposition:
- Package adc_capture_pkg holds:
  - the state enum typedef (IDLE, ARMED, CAPTURE, DONE);
  - the localparam for the default decimation width.
- Sub-module trig_edge_detect holds the trigger edge register plus the rising-edge pulse.
- Sequencer, counters and the BRAM write register live in the top.

Test Plan:
- Basic capture:
  - Stimulus: RAM_ADDR_BITS=4, capture_len=3, decim=0; arm, trigger edge, then valid samples 0x11,0x22,0x33,0x44,0x55.
  - Required response: writes 0x11@0, 0x22@1, 0x33@2, 0x44@3; 0x55 is not written; capture_done=1, last_address=3.
- Decimation:
  - Stimulus: decim=2, capture_len=1; valid samples 1..6.
  - Required response: writes 1@0 and 4@1 only; capture_done after the second write.
- Trigger held high across arm:
  - Stimulus: trigger held high across arm, then samples applied.
  - Required response: no writes; after trigger goes low then high, capture starts.
- Abort:
  - Stimulus: abort after the second write of a capture_len=7 run.
  - Required response: no writes after the abort cycle plus one; busy=0, capture_done=0.
  - Follow-up: a new arm and trigger restarts at address 0.
- Full depth:
  - Stimulus: RAM_ADDR_BITS=4, capture_len=15, continuous adc_valid.
  - Required response: 16 writes at addresses 0..15; last_address=15; no write to address 0 again.
- Async reset:
  - Stimulus: assert rst mid-CAPTURE between clock edges.
  - Required response: write_enable, busy and capture_done go to 0 immediately; state is IDLE after release.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture write-side controller.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DECIM_BITS_DEF = 8;

endpackage

// File: rtl/trig_edge_detect.sv
// Trigger history register and rising-edge pulse. The history tracks the trigger
// continuously, so a trigger that is already high when the block is armed does not fire.
module trig_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_trig,
  output logic o_rise
);

  logic r_trig_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_trig_d <= 1'b0;
    else       r_trig_d <= i_trig;
  end

  assign o_rise = i_trig & ~r_trig_d;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Write-side capture controller: arm, wait for a trigger edge, decimate the sample
// stream and write capture_len+1 samples to BRAM addresses starting at 0.
import adc_capture_pkg::*;

module adc_capture_ctrl #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 16,
  parameter int DECIM_BITS    = DECIM_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RAM_WIDTH-1:0]     adc_data,
  input  logic                     adc_valid,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trigger,
  input  logic [RAM_ADDR_BITS-1:0] capture_len,
  input  logic [DECIM_BITS-1:0]    decim,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] write_address,
  output logic [RAM_WIDTH-1:0]     write_data,
  output logic                     busy,
  output logic                     capture_done,
  output logic [RAM_ADDR_BITS-1:0] last_address
);

  state_t r_state, w_state_nxt;

  logic [RAM_ADDR_BITS-1:0] r_len, r_addr, r_wa, r_last;
  logic [DECIM_BITS-1:0]    r_decim, r_decim_cnt;
  logic [RAM_WIDTH-1:0]     r_wd;
  logic                     r_we, r_busy, r_done;
  logic                     w_rise, w_arm, w_fire, w_take, w_store, w_last;

  trig_edge_detect u_trig (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_trig (trigger),
    .o_rise (w_rise)
  );

  // abort overrides arm, trigger and sample acceptance in the same cycle
  assign w_arm   = arm & ~abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_fire  = (r_state == ARMED) & w_rise & ~abort;
  assign w_take  = (r_state == CAPTURE) & adc_valid & ~abort;
  assign w_store = w_take & (r_decim_cnt == '0);
  assign w_last  = w_store & (r_addr == r_len);

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (arm) w_state_nxt = ARMED;
        ARMED:   if (w_rise) w_state_nxt = CAPTURE;
        CAPTURE: if (w_last) w_state_nxt = DONE;
        DONE:    if (arm) w_state_nxt = ARMED;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_decim     <= '0;
      r_decim_cnt <= '0;
      r_addr      <= '0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_last      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ARMED) | (w_state_nxt == CAPTURE);
      r_done  <= (w_state_nxt == DONE);
      r_we    <= w_store;
      if (w_arm) begin
        r_len   <= capture_len;
        r_decim <= decim;
        r_addr  <= '0;
      end
      if (w_fire) r_decim_cnt <= '0;
      if (w_take) r_decim_cnt <= (r_decim_cnt == r_decim) ? '0 : r_decim_cnt + 1'b1;
      // counter may roll over on a full-depth final store; DONE is reached first
      if (w_store) begin
        r_wa   <= r_addr;
        r_wd   <= adc_data;
        r_addr <= r_addr + 1'b1;
        if (w_last) r_last <= r_addr;
      end
    end
  end

  assign write_enable  = r_we;
  assign write_address = r_wa;
  assign write_data    = r_wd;
  assign busy          = r_busy;
  assign capture_done  = r_done;
  assign last_address  = r_last;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a 4-bit address space.
module tb_adc_capture_ctrl;
  import adc_capture_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trigger = 1'b0;
  logic [AW-1:0] capture_len = '0;
  logic [DB-1:0] decim = '0;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          busy;
  logic          capture_done;
  logic [AW-1:0] last_address;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  logic          q_done[$];

  adc_capture_ctrl #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .DECIM_BITS(DB)) dut (
    .clk           (clk),
    .rst           (rst),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .arm           (arm),
    .abort         (abort),
    .trigger       (trigger),
    .capture_len   (capture_len),
    .decim         (decim),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .busy          (busy),
    .capture_done  (capture_done),
    .last_address  (last_address)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable) begin
      q_addr.push_back(write_address);
      q_data.push_back(write_data);
      q_done.push_back(capture_done);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_done.delete();
  endtask

  task automatic start_capture(input logic [AW-1:0] len, input logic [DB-1:0] dec);
    trigger = 1'b0;
    tick();
    capture_len = len;
    decim = dec;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trigger = 1'b1;
    tick();
  endtask

  task automatic feed(input logic [DW-1:0] d);
    adc_valid = 1'b1;
    adc_data = d;
    tick();
    adc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] samples[5];
    samples = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // reset values
    #3;
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", capture_done, 0);
    check("rst_last", last_address, 0);
    tick(2);
    rst = 1'b0;
    tick();

    // basic capture
    clear_log();
    start_capture(4'd3, 8'd0);
    check("basic_busy", busy, 1);
    for (int i = 0; i < 5; i++) feed(samples[i]);
    tick(2);
    check("basic_nwr", q_addr.size(), 4);
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      check("basic_addr", q_addr[i], i);
      check("basic_data", q_data[i], samples[i]);
    end
    if (q_done.size() == 4) check("basic_done_with_last", q_done[3], 1);
    check("basic_done", capture_done, 1);
    check("basic_last", last_address, 3);
    check("basic_idle_busy", busy, 0);

    // decimation by 3
    clear_log();
    start_capture(4'd1, 8'd2);
    for (int i = 1; i <= 6; i++) feed(8'(i));
    tick(2);
    check("dec_nwr", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check("dec_a0", q_addr[0], 0);
      check("dec_d0", q_data[0], 1);
      check("dec_done0", q_done[0], 0);
      check("dec_a1", q_addr[1], 1);
      check("dec_d1", q_data[1], 4);
      check("dec_done1", q_done[1], 1);
    end
    check("dec_last", last_address, 1);

    // trigger already high at arm time
    clear_log();
    trigger = 1'b1;
    tick();
    capture_len = 4'd0;
    decim = 8'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("hold_done_cleared", capture_done, 0);
    for (int i = 0; i < 4; i++) feed(8'hE0 + 8'(i));
    tick();
    check("hold_nwr", q_addr.size(), 0);
    check("hold_busy", busy, 1);
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    feed(8'hA5);
    tick(2);
    check("hold_nwr2", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      check("hold_addr", q_addr[0], 0);
      check("hold_data", q_data[0], 8'hA5);
    end
    check("hold_done", capture_done, 1);

    // abort after second write
    clear_log();
    start_capture(4'd7, 8'd0);
    feed(8'h10);
    feed(8'h20);
    abort = 1'b1;
    adc_valid = 1'b1;
    adc_data = 8'h30;
    tick();
    abort = 1'b0;
    check("abort_busy_now", busy, 0);
    for (int i = 0; i < 3; i++) feed(8'h40 + 8'(i));
    tick(2);
    check("abort_nwr", q_addr.size(), 2);
    if (q_addr.size() == 2) check("abort_d1", q_data[1], 8'h20);
    check("abort_busy", busy, 0);
    check("abort_done", capture_done, 0);

    clear_log();
    start_capture(4'd7, 8'd0);
    feed(8'h77);
    tick(2);
    check("rearm_nwr", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      check("rearm_addr", q_addr[0], 0);
      check("rearm_data", q_data[0], 8'h77);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // full depth
    clear_log();
    start_capture(4'd15, 8'd0);
    adc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      adc_data = 8'h80 + 8'(i);
      tick();
    end
    adc_valid = 1'b0;
    tick(2);
    check("full_nwr", q_addr.size(), 16);
    for (int i = 0; i < 16 && i < q_addr.size(); i++) begin
      check("full_addr", q_addr[i], i);
      check("full_data", q_data[i], 8'h80 + i);
    end
    check("full_last", last_address, 15);
    check("full_done", capture_done, 1);

    // async reset mid-capture
    clear_log();
    start_capture(4'd7, 8'd0);
    feed(8'h5A);
    check("ar_we_before", write_enable, 1);
    adc_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("ar_we", write_enable, 0);
    check("ar_busy", busy, 0);
    check("ar_done", capture_done, 0);
    tick();
    rst = 1'b0;
    clear_log();
    tick(3);
    adc_valid = 1'b0;
    check("ar_state", dut.r_state, IDLE);
    check("ar_nwr", q_addr.size(), 0);
    check("ar_busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
